// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Req/ack bridge from the multicycle controller to a
//               variable-latency word memory; stalls the controller via busy.
//               Optional access timeout guarded by macro MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 13,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              sel_src_pc,
    input  logic              sel_src_tr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] tr_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_start;
    logic              w_accept;
    logic              w_abort;
    logic [ADDR_W-1:0] w_addr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    assign w_start  = mem_read | mem_write;
    assign w_accept = (r_state == S_IDLE) && w_start;
    // sel_src_pc is only informative: pc is the fallback whenever TR is not selected
    assign w_addr   = sel_src_tr ? tr_addr : pc;

`ifdef MEM_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state != S_REQ) begin
            r_cnt <= '0;
        end else if (!mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_abort = (r_state == S_REQ) && !mem_ack &&
                     (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        mem_req = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = w_start;
                if (w_start) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || w_abort) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request attributes are captured once at accept and frozen for the whole access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= w_addr;
                r_wdata <= wdata;
                r_we    <= mem_write;
                if (mem_read && mem_write) begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == S_REQ) && mem_ack && !r_we) begin
                r_rdata <= mem_rdata;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Table-driven self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, sel_src_pc, sel_src_tr;
    logic [12:0] pc, tr_addr, wdata;
    logic        busy, done, err, mem_req, mem_we, mem_ack;
    logic [12:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W      (13),
        .DATA_W      (13),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .sel_src_pc (sel_src_pc),
        .sel_src_tr (sel_src_tr),
        .pc         (pc),
        .tr_addr    (tr_addr),
        .wdata      (wdata),
        .busy       (busy),
        .rdata      (rdata),
        .done       (done),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        spc;
        logic        str;
        logic [12:0] pc;
        logic [12:0] tr;
        logic [12:0] wd;
        int          delay;
        logic [12:0] mrd;
        logic [12:0] e_addr;
        logic        e_we;
        logic [12:0] e_wdata;
        logic [12:0] e_rdata;
        logic        e_err;
        int          e_edges;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 back in idle.
    task automatic run_txn(input vec_t v);
        int   edges;
        logic got;
        logic hold_ok;
        mem_read   = v.rd;
        mem_write  = v.wr;
        sel_src_pc = v.spc;
        sel_src_tr = v.str;
        pc         = v.pc;
        tr_addr    = v.tr;
        wdata      = v.wd;
        #1;
        check("busy_on_start", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        edges      = 1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        sel_src_pc = 1'b0;
        sel_src_tr = 1'b0;
        pc         = ~v.pc;
        tr_addr    = ~v.tr;
        wdata      = ~v.wd;
        check("req_after_accept", {31'd0, mem_req}, 32'd1);
        check("mem_addr", {19'd0, mem_addr}, {19'd0, v.e_addr});
        check("mem_we", {31'd0, mem_we}, {31'd0, v.e_we});
        check("mem_wdata", {19'd0, mem_wdata}, {19'd0, v.e_wdata});
        got     = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (i == v.delay) begin
                mem_ack   = 1'b1;
                mem_rdata = v.mrd;
            end
            @(posedge clk); #1;
            edges++;
            mem_ack   = 1'b0;
            mem_rdata = 13'h1FFF ^ v.mrd;
            if (done) got = 1'b1;
            else if (!mem_req || mem_addr !== v.e_addr || mem_we !== v.e_we ||
                     mem_wdata !== v.e_wdata || !busy) hold_ok = 1'b0;
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency_edges", edges, v.e_edges);
        check("req_held", {31'd0, hold_ok}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("req_in_done", {31'd0, mem_req}, 32'd0);
        check("rdata", {19'd0, rdata}, {19'd0, v.e_rdata});
        check("err", {31'd0, err}, {31'd0, v.e_err});
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   edges;
        logic got;
        //            rd  wr  spc str pc       tr       wd       dly mrd      e_addr   we  e_wdata  e_rdata  err edges
        tbl[0] = '{1'b1,1'b0,1'b1,1'b0,13'h0005,13'h00AA,13'h0123,0, 13'h01A3,13'h0005,1'b0,13'h0123,13'h01A3,1'b0,2};
        tbl[1] = '{1'b0,1'b1,1'b0,1'b1,13'h0011,13'h00F0,13'h0777,3, 13'h1FFF,13'h00F0,1'b1,13'h0777,13'h01A3,1'b0,5};
        tbl[2] = '{1'b1,1'b0,1'b1,1'b1,13'h0001,13'h0002,13'h0000,1, 13'h0BEE,13'h0002,1'b0,13'h0000,13'h0BEE,1'b0,3};
        tbl[3] = '{1'b1,1'b0,1'b0,1'b0,13'h1234,13'h0333,13'h0044,0, 13'h0042,13'h1234,1'b0,13'h0044,13'h0042,1'b0,2};
        tbl[4] = '{1'b1,1'b1,1'b1,1'b0,13'h0100,13'h0000,13'h1555,2, 13'h1ABC,13'h0100,1'b1,13'h1555,13'h0042,1'b1,4};
        tbl[5] = '{1'b1,1'b0,1'b1,1'b0,13'h0200,13'h0000,13'h0000,0, 13'h0777,13'h0200,1'b0,13'h0000,13'h0777,1'b1,2};
        tbl[6] = '{1'b0,1'b1,1'b0,1'b1,13'h0000,13'h0300,13'h0AAA,1, 13'h0999,13'h0300,1'b1,13'h0AAA,13'h0777,1'b1,3};

        rst_n = 1'b0;
        {mem_read, mem_write, sel_src_pc, sel_src_tr, mem_ack} = '0;
        pc = '0; tr_addr = '0; wdata = '0; mem_rdata = '0;
        #12;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {19'd0, mem_addr}, 32'd0);
        check("rst_wdata", {19'd0, mem_wdata}, 32'd0);
        check("rst_rdata", {19'd0, rdata}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) run_txn(tbl[k]);

        // Ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 13'h1111;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("idle_ack_rdata", {19'd0, rdata}, 32'h0777);
        check("idle_ack_done", {31'd0, done}, 32'd0);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);

        // Strobe held through DONE: not accepted there, accepted from IDLE next cycle
        mem_read = 1'b1; sel_src_tr = 1'b1; tr_addr = 13'h0055;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 13'h0101;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("hold_done", {31'd0, done}, 32'd1);
        check("hold_busy_done", {31'd0, busy}, 32'd0);
        check("hold_rdata1", {19'd0, rdata}, 32'h0101);
        @(posedge clk); #1;
        check("hold_idle_req", {31'd0, mem_req}, 32'd0);
        check("hold_idle_busy", {31'd0, busy}, 32'd1);
        check("hold_idle_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; sel_src_tr = 1'b0;
        check("hold_reaccept", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 13'h0202;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("hold_done2", {31'd0, done}, 32'd1);
        check("hold_rdata2", {19'd0, rdata}, 32'h0202);
        @(posedge clk); #1;

        // Reset in the middle of REQ aborts immediately
        mem_read = 1'b1; sel_src_pc = 1'b1; pc = 13'h0ABC;
        @(posedge clk); #1;
        mem_read = 1'b0; sel_src_pc = 1'b0;
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, mem_req}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_rdata", {19'd0, rdata}, 32'd0);

        run_txn(tbl[0]);

        // No ack at all: bounded wait for done
        mem_read = 1'b1; sel_src_pc = 1'b1; pc = 13'h0010; mem_rdata = 13'h0666;
        @(posedge clk); #1;
        mem_read = 1'b0; sel_src_pc = 1'b0;
        edges = 1;
        got   = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            edges++;
            if (done) got = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        check("to_done_seen", {31'd0, got}, 32'd1);
        check("to_edges", edges, 32'd5);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_req", {31'd0, mem_req}, 32'd0);
        check("to_rdata", {19'd0, rdata}, 32'h01A3);
        @(posedge clk); #1;
        check("to_done_end", {31'd0, done}, 32'd0);
`else
        check("noto_done", {31'd0, got}, 32'd0);
        check("noto_req", {31'd0, mem_req}, 32'd1);
        check("noto_err", {31'd0, err}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 13'h0321;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("noto_late_done", {31'd0, done}, 32'd1);
        check("noto_rdata", {19'd0, rdata}, 32'h0321);
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
